// File: rtl/a_pass_entry_if.sv
// Keypad-to-checker bus for the digital lock password entry block.
// master : the digit collector (a_pass_entry) -- takes key events and the
//          checker's gen_rst, drives the collected password and status.
// slave  : the surrounding logic (keypad debouncer + a_checking_pass side).
interface a_pass_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        gen_rst;
    logic [15:0] pw_16bit;
    logic [2:0]  digit_cnt;
    logic        enough;
    logic        entry_err;
    logic        entry_timeout;

    modport master (
        input  key_valid,
        input  key_code,
        input  gen_rst,
        output pw_16bit,
        output digit_cnt,
        output enough,
        output entry_err,
        output entry_timeout
    );

    modport slave (
        output key_valid,
        output key_code,
        output gen_rst,
        input  pw_16bit,
        input  digit_cnt,
        input  enough,
        input  entry_err,
        input  entry_timeout
    );
endinterface

// File: rtl/a_pass_entry.sv
// Keypad digit collector for the digital lock.
// Shifts decimal digits into a 16-bit BCD word (newest digit in [3:0]),
// raises enough once four digits are held, and clears only after the
// checker has pulsed gen_rst high and back low.
// Optional feature: define ENTRY_TIMEOUT_EN to discard an unfinished entry
// after TIMEOUT_CYC clocks without an accepted key.
module a_pass_entry #(
    parameter int              DIGITS      = 4,
    parameter int              TO_W        = 28,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 28'd250000000
) (
    input  logic              clk,
    input  logic              reset,
    a_pass_entry_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no digits held
        ENTRY = 2'd1,   // 1..DIGITS-1 digits held
        FULL  = 2'd2,   // all digits held, waiting for checker
        ACK   = 2'd3    // checker has seen the password, waiting for its release
    } state_t;

    // Digit count value that, when one more digit arrives, completes the entry.
    localparam logic [2:0] LAST_CNT = 3'(DIGITS - 1);

    state_t      state_q, state_d;
    logic [15:0] pw_q, pw_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        enough_q, enough_d;
    logic        err_q, err_d;

    logic        gen_meta, gs;
    logic        is_digit, is_bksp, is_clear, key_ok;
    logic        expired;

    assign is_digit = (bus.key_code <= 4'd9);
    assign is_bksp  = (bus.key_code == 4'hA);
    assign is_clear = (bus.key_code == 4'hB);
    assign key_ok   = is_digit | is_bksp | is_clear;

    // Two-flop synchroniser bringing the checker's gen_rst into this clock domain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            gen_meta <= 1'b0;
            gs       <= 1'b0;
        end else begin
            gen_meta <= bus.gen_rst;
            gs       <= gen_meta;
        end
    end

    // State and all outputs are registered here from the next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pw_q     <= '0;
            cnt_q    <= '0;
            enough_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pw_q     <= pw_d;
            cnt_q    <= cnt_d;
            enough_q <= enough_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-output decode for key events and checker handshake.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        pw_d     = pw_q;
        cnt_d    = cnt_q;
        enough_d = enough_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        pw_d    = {pw_q[11:0], bus.key_code};
                        cnt_d   = cnt_q + 3'd1;
                        state_d = ENTRY;
                    end else if (is_clear) begin
                        pw_d  = '0;
                        cnt_d = '0;
                    end else begin
                        // Backspace with nothing held, or an invalid code.
                        err_d = 1'b1;
                    end
                end
            end

            ENTRY: begin
                if (expired) begin
                    // Inactivity expiry wins over a key arriving in the same cycle.
                    pw_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    err_d   = bus.key_valid;
                end else if (bus.key_valid) begin
                    if (is_digit) begin
                        pw_d  = {pw_q[11:0], bus.key_code};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d  = FULL;
                            enough_d = 1'b1;
                        end
                    end else if (is_bksp) begin
                        pw_d  = {4'h0, pw_q[15:4]};
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_d = IDLE;
                        end
                    end else if (is_clear) begin
                        pw_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FULL: begin
                // Entry is frozen until the checker answers.
                err_d = bus.key_valid;
                if (gs) begin
                    state_d = ACK;
                end
            end

            ACK: begin
                // Any key here, including in the release cycle, is dropped.
                err_d = bus.key_valid;
                if (!gs) begin
                    pw_d     = '0;
                    cnt_d    = '0;
                    enough_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ENTRY_TIMEOUT_EN
    // Last count value before an idle partial entry is discarded.
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            to_q;

    assign expired = (state_q == ENTRY) && (tcnt_q == TO_LAST);

    // Counter advances only while staying in ENTRY without an accepted key.
    always_comb begin
        tcnt_d = '0;
        if ((state_q == ENTRY) && (state_d == ENTRY) && !(bus.key_valid && key_ok)) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // Inactivity counter and the registered timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= expired;
        end
    end

    assign bus.entry_timeout = to_q;
`else
    // Without the timeout feature a partial entry is held indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign expired            = 1'b0;
    assign bus.entry_timeout  = 1'b0;
`endif

    assign bus.pw_16bit  = pw_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.enough    = enough_q;
    assign bus.entry_err = err_q;

endmodule
